// File: rtl/hex_display_driver.sv
// hex_display_driver
//   Drives a 4-digit multiplexed seven-segment display from 16-bit words.
//   A single-entry pending buffer accepts a word at any time. The pending
//   word moves to the displayed value only at a scan-frame boundary, so the
//   display never shows a half-updated value. Busy/Ovr give firmware a
//   status pair it can poll.
//
//   Optional feature macro: HEXDISP_LZ_BLANK_EN (leading-zero suppression).
//
// Parameters
//   SCAN_DIV   clock cycles each digit stays enabled (>= 2)
// Ports
//   i_clk      system clock, rising edge
//   i_clr      synchronous active-high reset
//   i_ld       load strobe, one cycle per write
//   i_din      16-bit word to display, sampled when i_ld = 1
//   i_blank    forces all digits off; scanning and commits continue
//   i_ovr_clr  clears the sticky overrun flag
//   o_busy     a pending word has not been committed yet
//   o_ovr      sticky: a pending word was overwritten before commit
//   o_disp     currently committed display value
//   o_an       one-hot digit enable, active-high, bit 0 = least significant
//   o_seg      segments {g,f,e,d,c,b,a}, active-high
module hex_display_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_ld,
  input  logic [15:0] i_din,
  input  logic        i_blank,
  input  logic        i_ovr_clr,
  output logic        o_busy,
  output logic        o_ovr,
  output logic [15:0] o_disp,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg
);

  localparam int            PW   = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] f_hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [PW-1:0] r_pcnt;
  logic [1:0]    r_dig;
  logic [15:0]   r_pend;
  logic          r_busy;
  logic          r_ovr;
  logic [15:0]   r_disp;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_wrap;
  logic          w_boundary;
  logic          w_overrun;
  logic [3:0]    w_nibble;
  logic          w_show;

  // Scan timing, overrun detection and the nibble/visibility of the current digit
  always_comb begin
    w_wrap     = (r_pcnt == PMAX);
    w_boundary = w_wrap && (r_dig == 2'd3);
    // A write landing on the boundary replaces a word that is committing, not lost
    w_overrun  = i_ld && r_busy && !w_boundary;
    case (r_dig)
      2'd0:    w_nibble = r_disp[3:0];
      2'd1:    w_nibble = r_disp[7:4];
      2'd2:    w_nibble = r_disp[11:8];
      2'd3:    w_nibble = r_disp[15:12];
      default: w_nibble = 4'h0;
    endcase
`ifdef HEXDISP_LZ_BLANK_EN
    // Digit k is hidden while every nibble from k upward is zero; digit 0 always shows
    case (r_dig)
      2'd3:    w_show = |r_disp[15:12];
      2'd2:    w_show = |r_disp[15:8];
      2'd1:    w_show = |r_disp[15:4];
      default: w_show = 1'b1;
    endcase
`else
    w_show = 1'b1;
`endif
  end

  // Scan counters, pending buffer, commit, status flags and registered digit outputs
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_pcnt <= '0;
      r_dig  <= 2'd0;
      r_pend <= 16'h0000;
      r_busy <= 1'b0;
      r_ovr  <= 1'b0;
      r_disp <= 16'h0000;
      r_an   <= 4'b0000;
      r_seg  <= 7'h00;
    end else begin
      if (w_wrap) begin
        r_pcnt <= '0;
        r_dig  <= r_dig + 2'd1;
      end else begin
        r_pcnt <= r_pcnt + PW'(1);
      end

      if (w_boundary && r_busy) begin
        r_disp <= r_pend;
        r_busy <= 1'b0;
      end

      // Later assignment keeps Busy high when a new word arrives on the commit edge
      if (i_ld) begin
        r_pend <= i_din;
        r_busy <= 1'b1;
      end

      // Setting beats clearing when both happen together
      if (w_overrun) begin
        r_ovr <= 1'b1;
      end else if (i_ovr_clr) begin
        r_ovr <= 1'b0;
      end

      if (i_blank || !w_show) begin
        r_an  <= 4'b0000;
        r_seg <= 7'h00;
      end else begin
        r_an  <= 4'b0001 << r_dig;
        r_seg <= f_hex_to_seg(w_nibble);
      end
    end
  end

  assign o_busy = r_busy;
  assign o_ovr  = r_ovr;
  assign o_disp = r_disp;
  assign o_an   = r_an;
  assign o_seg  = r_seg;

endmodule
